// File: rtl/pipe_ctrl_regs.sv
// Pipeline control registers IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage valid
// bits and stall/bubble/retire performance counters feeding the hazard unit.
module pipe_ctrl_regs #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned RET_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      InstrF,
   input  logic [31:0]      PCPlus4F,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             FlushE,
   input  logic             RegWriteD,
   input  logic             MemtoRegD,
   input  logic             MemWriteD,
   input  logic             RegDstD,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCPlus4D,
   output logic [4:0]       rsD,
   output logic [4:0]       rtD,
   output logic [4:0]       rdD,
   output logic [4:0]       rsE,
   output logic [4:0]       rtE,
   output logic [4:0]       rdE,
   output logic             RegWriteE,
   output logic             MemtoRegE,
   output logic             MemWriteE,
   output logic [4:0]       WriteRegE,
   output logic             RegWriteM,
   output logic             MemtoRegM,
   output logic             MemWriteM,
   output logic [4:0]       WriteRegM,
   output logic             RegWriteW,
   output logic             MemtoRegW,
   output logic [4:0]       WriteRegW,
   output logic             validD,
   output logic             validE,
   output logic             validM,
   output logic             validW,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] BubbleCnt,
   output logic [RET_W-1:0] RetireCnt
);

   logic [31:0]      instr_d_q, instr_d_d;
   logic [31:0]      pc4_d_q, pc4_d_d;
   logic             valid_d_q, valid_d_d;

   logic [4:0]       rs_e_q, rs_e_d;
   logic [4:0]       rt_e_q, rt_e_d;
   logic [4:0]       rd_e_q, rd_e_d;
   logic             regdst_e_q, regdst_e_d;
   logic             regwrite_e_q, regwrite_e_d;
   logic             memtoreg_e_q, memtoreg_e_d;
   logic             memwrite_e_q, memwrite_e_d;
   logic             valid_e_q, valid_e_d;

   logic             regwrite_m_q, regwrite_m_d;
   logic             memtoreg_m_q, memtoreg_m_d;
   logic             memwrite_m_q, memwrite_m_d;
   logic [4:0]       writereg_m_q, writereg_m_d;
   logic             valid_m_q, valid_m_d;

   logic             regwrite_w_q, regwrite_w_d;
   logic             memtoreg_w_q, memtoreg_w_d;
   logic [4:0]       writereg_w_q, writereg_w_d;
   logic             valid_w_q, valid_w_d;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [RET_W-1:0] retire_cnt_q, retire_cnt_d;

   logic [4:0]       writereg_e;

   assign writereg_e = regdst_e_q ? rd_e_q : rt_e_q;

   // IF/ID: stall outranks flush, so a flush arriving during a stall is dropped
   always_comb begin
      instr_d_d = instr_d_q;
      pc4_d_d   = pc4_d_q;
      valid_d_d = valid_d_q;
      if (!StallD) begin
         if (FlushD) begin
            instr_d_d = '0;
            pc4_d_d   = '0;
            valid_d_d = 1'b0;
         end else begin
            instr_d_d = InstrF;
            pc4_d_d   = PCPlus4F;
            valid_d_d = 1'b1;
         end
      end
   end

   // ID/EX: write enables are gated by validD so a flushed D slot never writes
   always_comb begin
      rs_e_d       = '0;
      rt_e_d       = '0;
      rd_e_d       = '0;
      regdst_e_d   = 1'b0;
      regwrite_e_d = 1'b0;
      memtoreg_e_d = 1'b0;
      memwrite_e_d = 1'b0;
      valid_e_d    = 1'b0;
      if (!FlushE) begin
         rs_e_d       = instr_d_q[25:21];
         rt_e_d       = instr_d_q[20:16];
         rd_e_d       = instr_d_q[15:11];
         regdst_e_d   = RegDstD;
         regwrite_e_d = RegWriteD & valid_d_q;
         memtoreg_e_d = MemtoRegD;
         memwrite_e_d = MemWriteD & valid_d_q;
         valid_e_d    = valid_d_q;
      end
   end

   always_comb begin
      regwrite_m_d = regwrite_e_q;
      memtoreg_m_d = memtoreg_e_q;
      memwrite_m_d = memwrite_e_q;
      writereg_m_d = writereg_e;
      valid_m_d    = valid_e_q;

      regwrite_w_d = regwrite_m_q;
      memtoreg_w_d = memtoreg_m_q;
      writereg_w_d = writereg_m_q;
      valid_w_d    = valid_m_q;
   end

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (StallD && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (FlushE && (bubble_cnt_q != '1))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      if (valid_w_q)
         retire_cnt_d = retire_cnt_q + RET_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instr_d_q    <= '0;
         pc4_d_q      <= '0;
         valid_d_q    <= 1'b0;
         rs_e_q       <= '0;
         rt_e_q       <= '0;
         rd_e_q       <= '0;
         regdst_e_q   <= 1'b0;
         regwrite_e_q <= 1'b0;
         memtoreg_e_q <= 1'b0;
         memwrite_e_q <= 1'b0;
         valid_e_q    <= 1'b0;
         regwrite_m_q <= 1'b0;
         memtoreg_m_q <= 1'b0;
         memwrite_m_q <= 1'b0;
         writereg_m_q <= '0;
         valid_m_q    <= 1'b0;
         regwrite_w_q <= 1'b0;
         memtoreg_w_q <= 1'b0;
         writereg_w_q <= '0;
         valid_w_q    <= 1'b0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         retire_cnt_q <= '0;
      end else begin
         instr_d_q    <= instr_d_d;
         pc4_d_q      <= pc4_d_d;
         valid_d_q    <= valid_d_d;
         rs_e_q       <= rs_e_d;
         rt_e_q       <= rt_e_d;
         rd_e_q       <= rd_e_d;
         regdst_e_q   <= regdst_e_d;
         regwrite_e_q <= regwrite_e_d;
         memtoreg_e_q <= memtoreg_e_d;
         memwrite_e_q <= memwrite_e_d;
         valid_e_q    <= valid_e_d;
         regwrite_m_q <= regwrite_m_d;
         memtoreg_m_q <= memtoreg_m_d;
         memwrite_m_q <= memwrite_m_d;
         writereg_m_q <= writereg_m_d;
         valid_m_q    <= valid_m_d;
         regwrite_w_q <= regwrite_w_d;
         memtoreg_w_q <= memtoreg_w_d;
         writereg_w_q <= writereg_w_d;
         valid_w_q    <= valid_w_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign InstrD    = instr_d_q;
   assign PCPlus4D  = pc4_d_q;
   assign rsD       = instr_d_q[25:21];
   assign rtD       = instr_d_q[20:16];
   assign rdD       = instr_d_q[15:11];
   assign rsE       = rs_e_q;
   assign rtE       = rt_e_q;
   assign rdE       = rd_e_q;
   assign RegWriteE = regwrite_e_q;
   assign MemtoRegE = memtoreg_e_q;
   assign MemWriteE = memwrite_e_q;
   assign WriteRegE = writereg_e;
   assign RegWriteM = regwrite_m_q;
   assign MemtoRegM = memtoreg_m_q;
   assign MemWriteM = memwrite_m_q;
   assign WriteRegM = writereg_m_q;
   assign RegWriteW = regwrite_w_q;
   assign MemtoRegW = memtoreg_w_q;
   assign WriteRegW = writereg_w_q;
   assign validD    = valid_d_q;
   assign validE    = valid_e_q;
   assign validM    = valid_m_q;
   assign validW    = valid_w_q;
   assign StallCnt  = stall_cnt_q;
   assign BubbleCnt = bubble_cnt_q;
   assign RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Randomized and directed bench for pipe_ctrl_regs against a stage-record model.
module tb_pipe_ctrl_regs;
   localparam int CNT_W = 16;
   // Narrowed retire counter so its wrap is reachable within the saturation run
   localparam int RET_W = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [31:0]      InstrF, PCPlus4F;
   logic             StallD, FlushD, FlushE;
   logic             RegWriteD, MemtoRegD, MemWriteD, RegDstD;
   logic [31:0]      InstrD, PCPlus4D;
   logic [4:0]       rsD, rtD, rdD, rsE, rtE, rdE;
   logic             RegWriteE, MemtoRegE, MemWriteE;
   logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
   logic             RegWriteM, MemtoRegM, MemWriteM, RegWriteW, MemtoRegW;
   logic             validD, validE, validM, validW;
   logic [CNT_W-1:0] StallCnt, BubbleCnt;
   logic [RET_W-1:0] RetireCnt;

   always #5 clk = ~clk;

   pipe_ctrl_regs #(.CNT_W(CNT_W), .RET_W(RET_W)) dut (
      .clk(clk), .reset_n(reset_n), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
      .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .RegDstD(RegDstD),
      .InstrD(InstrD), .PCPlus4D(PCPlus4D), .rsD(rsD), .rtD(rtD), .rdD(rdD),
      .rsE(rsE), .rtE(rtE), .rdE(rdE),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .WriteRegE(WriteRegE),
      .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .WriteRegM(WriteRegM),
      .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW),
      .validD(validD), .validE(validE), .validM(validM), .validW(validW),
      .StallCnt(StallCnt), .BubbleCnt(BubbleCnt), .RetireCnt(RetireCnt)
   );

   typedef struct { bit v; bit [31:0] instr; bit [31:0] pc; } dstg_t;
   typedef struct { bit v; bit [4:0] rs; bit [4:0] rt; bit [4:0] rd; bit dst; bit rw; bit m2r; bit mw; } estg_t;
   typedef struct { bit v; bit rw; bit m2r; bit mw; bit [4:0] wr; } mstg_t;

   dstg_t  sD;
   estg_t  sE;
   mstg_t  sM, sW;
   longint n_stall, n_bubble, n_ret;
   bit     m_ok = 1'b0;
   int     n_chk = 0;
   int     n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Advance the model across one rising edge using the inputs the DUT sampled
   task automatic model_edge();
      if (!reset_n) begin
         sD = '{default: '0}; sE = '{default: '0}; sM = '{default: '0}; sW = '{default: '0};
         n_stall = 0; n_bubble = 0; n_ret = 0; m_ok = 1'b1;
         return;
      end
      if (sW.v) n_ret++;
      if (StallD) n_stall++;
      if (FlushE) n_bubble++;
      sW = '{v: sM.v, rw: sM.rw, m2r: sM.m2r, mw: 1'b0, wr: sM.wr};
      sM = '{v: sE.v, rw: sE.rw, m2r: sE.m2r, mw: sE.mw, wr: (sE.dst ? sE.rd : sE.rt)};
      if (FlushE) sE = '{default: '0};
      else sE = '{v: sD.v, rs: sD.instr[25:21], rt: sD.instr[20:16], rd: sD.instr[15:11],
                  dst: RegDstD, rw: RegWriteD & sD.v, m2r: MemtoRegD, mw: MemWriteD & sD.v};
      if (!StallD) begin
         if (FlushD) sD = '{default: '0};
         else sD = '{v: 1'b1, instr: InstrF, pc: PCPlus4F};
      end
   endtask

   function automatic longint sat(input longint n);
      longint mx = (longint'(1) << CNT_W) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic check_model();
      if (!m_ok) return;
      chk("InstrD", InstrD, sD.instr);       chk("PCPlus4D", PCPlus4D, sD.pc);
      chk("rsD", rsD, sD.instr[25:21]);      chk("rtD", rtD, sD.instr[20:16]);
      chk("rdD", rdD, sD.instr[15:11]);      chk("validD", validD, sD.v);
      chk("rsE", rsE, sE.rs);                chk("rtE", rtE, sE.rt);
      chk("rdE", rdE, sE.rd);                chk("validE", validE, sE.v);
      chk("RegWriteE", RegWriteE, sE.rw);    chk("MemtoRegE", MemtoRegE, sE.m2r);
      chk("MemWriteE", MemWriteE, sE.mw);    chk("WriteRegE", WriteRegE, sE.dst ? sE.rd : sE.rt);
      chk("RegWriteM", RegWriteM, sM.rw);    chk("MemtoRegM", MemtoRegM, sM.m2r);
      chk("MemWriteM", MemWriteM, sM.mw);    chk("WriteRegM", WriteRegM, sM.wr);
      chk("validM", validM, sM.v);
      chk("RegWriteW", RegWriteW, sW.rw);    chk("MemtoRegW", MemtoRegW, sW.m2r);
      chk("WriteRegW", WriteRegW, sW.wr);    chk("validW", validW, sW.v);
      chk("StallCnt", StallCnt, sat(n_stall));
      chk("BubbleCnt", BubbleCnt, sat(n_bubble));
      chk("RetireCnt", RetireCnt, n_ret % (longint'(1) << RET_W));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic idle_inputs();
      reset_n = 1'b1; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      RegWriteD = 1'b0; MemtoRegD = 1'b0; MemWriteD = 1'b0; RegDstD = 1'b0;
      InstrF = '0; PCPlus4F = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      bit wrap_now;
      idle_inputs();
      do_reset();
      chk("rst_validD", validD, 0);   chk("rst_validW", validW, 0);
      chk("rst_InstrD", InstrD, 0);   chk("rst_RetireCnt", RetireCnt, 0);

      // Stream: add $8,$9,$10 followed by three more
      InstrF = 32'h012A4020; PCPlus4F = 32'h4;
      step();
      chk("lit_rsD", rsD, 9); chk("lit_rtD", rtD, 10); chk("lit_rdD", rdD, 8);
      RegWriteD = 1'b1; RegDstD = 1'b1; InstrF = 32'h014B6022; PCPlus4F = 32'h8;
      step();
      chk("lit_WriteRegE", WriteRegE, 8);
      InstrF = 32'h016C7024; PCPlus4F = 32'hC;
      step();
      chk("lit_WriteRegM", WriteRegM, 8);
      InstrF = 32'h018D7825; PCPlus4F = 32'h10;
      step();
      chk("lit_WriteRegW", WriteRegW, 8); chk("lit_validW", validW, 1);
      step();
      chk("lit_RetireCnt1", RetireCnt, 1);

      // Load-use: lw $9,0($8) then add reading $9
      do_reset();
      InstrF = 32'h8D090000;
      step();
      RegWriteD = 1'b1; MemtoRegD = 1'b1; InstrF = 32'h012A4020;
      step();
      StallD = 1'b1; FlushE = 1'b1; InstrF = 32'h014B6022;
      step();
      chk("lu_InstrD", InstrD, 32'h012A4020); chk("lu_validE", validE, 0);
      chk("lu_RegWriteE", RegWriteE, 0);
      chk("lu_StallCnt", StallCnt, 1); chk("lu_BubbleCnt", BubbleCnt, 1);
      StallD = 1'b0; FlushE = 1'b0; MemtoRegD = 1'b0; RegDstD = 1'b1;
      step();
      chk("lu_rsE", rsE, 9); chk("lu_rtE", rtE, 10); chk("lu_rdE", rdE, 8); chk("lu_validE2", validE, 1);

      // Stall beats FlushD, then FlushD alone clears IF/ID
      StallD = 1'b1; FlushD = 1'b1;
      step();
      chk("sf_InstrD_hold", InstrD, 32'h014B6022); chk("sf_validD_hold", validD, 1);
      StallD = 1'b0;
      step();
      chk("sf_InstrD_clr", InstrD, 0); chk("sf_validD_clr", validD, 0);
      FlushD = 1'b0;

      // Reset with instructions in flight
      for (int i = 0; i < 3; i++) begin
         InstrF = $urandom; PCPlus4F = $urandom;
         step();
      end
      reset_n = 1'b0;
      step();
      chk("mr_validD", validD, 0); chk("mr_validE", validE, 0);
      chk("mr_validM", validM, 0); chk("mr_validW", validW, 0);
      chk("mr_WriteRegE", WriteRegE, 0); chk("mr_WriteRegM", WriteRegM, 0);
      chk("mr_WriteRegW", WriteRegW, 0);
      chk("mr_StallCnt", StallCnt, 0); chk("mr_BubbleCnt", BubbleCnt, 0);
      chk("mr_RetireCnt", RetireCnt, 0);
      reset_n = 1'b1;
      step();
      chk("mr_RetireCnt_after", RetireCnt, 0);

      // Random traffic, including occasional resets
      for (int i = 0; i < 400; i++) begin
         reset_n   = ($urandom_range(0, 39) != 0);
         StallD    = ($urandom_range(0, 3) == 0);
         FlushE    = StallD ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         FlushD    = ($urandom_range(0, 4) == 0);
         RegWriteD = $urandom; MemtoRegD = $urandom; MemWriteD = $urandom; RegDstD = $urandom;
         InstrF    = $urandom; PCPlus4F = $urandom;
         step();
      end

      // Long stall with a valid D: StallCnt saturates, retire counter wraps
      do_reset();
      InstrF = 32'h012A4020; RegWriteD = 1'b1; RegDstD = 1'b1;
      step();
      StallD = 1'b1;
      for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
         wrap_now = (n_ret == (longint'(1) << RET_W) - 1) && sW.v;
         step();
         if (wrap_now) chk("ret_wrap", RetireCnt, 0);
      end
      chk("sat_StallCnt", StallCnt, 16'hFFFF);
      step();
      chk("sat_StallCnt_hold", StallCnt, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
- Holds the pipeline registers that carry instruction, register numbers and control bits from fetch through writeback: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sits directly upstream of the hazard unit.
  - Produces rsD/rtD, rsE/rtE, WriteRegE/M/W, RegWriteE/M/W and MemtoRegE/M.
  - Consumes the hazard unit's StallD/FlushE, plus FlushD from branch/jump resolution.
- Tracks a valid bit per stage and maintains stall, bubble and retire counters for performance debug.

Parameters:
- CNT_W, 16, width of the saturating stall and bubble counters.
- RET_W, 32, width of the wrapping retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- InstrF  in  32  fetched instruction.
- PCPlus4F  in  32  fetch PC+4.
- StallD  in  1  hold IF/ID register (from hazard unit).
- FlushD  in  1  clear IF/ID register (branch taken / jump).
- FlushE  in  1  load bubble into ID/EX register (from hazard unit).
- RegWriteD, MemtoRegD, MemWriteD, RegDstD  in  1 each  decoded control for the instruction in D.
- InstrD  out  32  IF/ID instruction.
- PCPlus4D  out  32  IF/ID PC+4.
- rsD, rtD, rdD  out  5 each  InstrD[25:21], [20:16], [15:11].
- rsE, rtE, rdE  out  5 each  ID/EX register numbers.
- RegWriteE, MemtoRegE, MemWriteE  out  1 each  ID/EX control.
- WriteRegE  out  5  RegDstE ? rdE : rtE (combinational).
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  EX/MEM control.
- WriteRegM  out  5  EX/MEM destination.
- RegWriteW, MemtoRegW  out  1 each  MEM/WB control.
- WriteRegW  out  5  MEM/WB destination.
- validD, validE, validM, validW  out  1 each  stage holds a real instruction.
- StallCnt  out  CNT_W  cycles with StallD=1, saturating.
- BubbleCnt  out  CNT_W  cycles with FlushE=1, saturating.
- RetireCnt  out  RET_W  cycles with validW=1, wraps.

Behaviour:
- Reset (reset_n=0 at a rising edge) forces every register and counter to 0 on that edge.
  - InstrD=0 (sll $0 NOP), so rsD=rtD=rdD=0.
  - All control bits 0 and all valid bits 0.
  - Reset has priority over stall and flush in the same cycle.
- Reset mid-operation discards all in-flight instructions. No output retains a pre-reset value after the reset edge.
- IF/ID, priority high to low:
  1. StallD=1: hold InstrD, PCPlus4D and validD. FlushD is ignored that cycle.
  2. FlushD=1: InstrD=0, PCPlus4D=0, validD=0.
  3. Otherwise: load InstrF and PCPlus4F, and set validD=1.
- ID/EX is never stalled.
  - FlushE=1: rsE, rtE, rdE, RegDstE, RegWriteE, MemtoRegE, MemWriteE and validE all load 0.
  - Otherwise the stage loads rsD, rtD, rdD and the D controls, with validE=validD.
  - RegWriteE/MemWriteE load RegWriteD&validD and MemWriteD&validD, so a flushed D never writes.
- EX/MEM loads unconditionally: RegWriteM, MemtoRegM, MemWriteM, WriteRegM and validM from the E stage.
- MEM/WB loads unconditionally: RegWriteW, MemtoRegW, WriteRegW and validW from the M stage.
- Latency: an instruction loaded into IF/ID reaches W 3 cycles later, plus 1 cycle per StallD cycle.
- StallD and FlushE are normally asserted together by the hazard unit.
  - D holds while E takes a bubble.
  - The held instruction re-enters E on the first cycle with StallD=0.
- StallCnt increments when StallD=1. BubbleCnt increments when FlushE=1. Both saturate at all-ones and never wrap. Neither counts during reset.
- RetireCnt increments when validW=1 and wraps from all-ones to 0.
- No combinational path exists from StallD/FlushE/FlushD to any output. WriteRegE and the rsD/rtD/rdD slices are the only combinational outputs, and each depends only on state.

Test Plan:
- Reset, then stream 4 instructions (InstrF=0x012A4020 add $8,$9,$10, then 3 more).
  - Required: rsD=9, rtD=10, rdD=8 one cycle after load.
  - With RegDstD=1: WriteRegE=8, then WriteRegM=8, then WriteRegW=8 on successive cycles.
  - RetireCnt=1 on the cycle after validW first rises.
- Load-use stall: assert StallD=FlushE=1 for 1 cycle while lw is in E.
  - Required: InstrD unchanged, validE=0, RegWriteE=0, StallCnt=1, BubbleCnt=1.
  - The held instruction appears in E the next cycle.
- StallD=1 and FlushD=1 in the same cycle -> IF/ID holds its value. The next cycle, with StallD=0 and FlushD=1, gives InstrD=0 and validD=0.
- Hold StallD=1 for 2^CNT_W+5 cycles -> StallCnt=0xFFFF and stays there.
- Drive reset_n=0 for 1 cycle with 3 valid instructions in flight -> all valid bits, WriteRegE/M/W and all counters are 0 after the edge. RetireCnt does not increment for the discarded instructions.
- Preload RetireCnt to 0xFFFFFFFF via a long run (or force) and retire 1 instruction -> RetireCnt=0.
